// File: rtl/gate_bist.sv
// gate_bist: built-in stimulus/checker for a 2-input combinational gate.
// It drives the vectors {a,b} = 00, 01, 10, 11 in turn and holds each one for
// HOLD cycles. On the last hold cycle of each vector it samples y_in and
// compares it with EXPECTED[{a,b}]. Mismatching vectors are collected in
// fail_mask, and an overall pass flag is produced when the run ends.
//
// Parameters:
//   EXPECTED  expected gate output per vector, bit index = {a,b} (default AND)
//   HOLD      cycles each vector is held, legal range 1..255
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      run request, only sampled while idle
//   y_in       output of the gate under test (combinational from a_out/b_out)
//   a_out      gate input a
//   b_out      gate input b
//   busy       high while vectors are being driven
//   done       one-cycle pulse, one cycle after the run's final sample
//   pass       1 = every vector matched; valid from done until the next start
//   fail_mask  bit {a,b} set if that vector mismatched; same validity as pass
module gate_bist #(
    parameter logic [3:0]  EXPECTED = 4'b1000,
    parameter int unsigned HOLD     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter value on the final (sampling) cycle of each vector.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    // Expected gate output for a given input vector.
    function automatic logic expected_bit(input logic [1:0] vec);
        return EXPECTED[vec];
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  vec_r, vec_s;
    logic [7:0]  hold_cnt_r, hold_cnt_s;
    logic        a_r, a_s;
    logic        b_r, b_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        pass_r, pass_s;
    logic [3:0]  fail_mask_r, fail_mask_s;

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        state_s     = state_r;
        vec_s       = vec_r;
        hold_cnt_s  = hold_cnt_r;
        a_s         = a_r;
        b_s         = b_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        pass_s      = pass_r;
        fail_mask_s = fail_mask_r;

        case (state_r)
            IDLE: begin
                a_s    = 1'b0;
                b_s    = 1'b0;
                busy_s = 1'b0;
                if (start) begin
                    // Vector 00 is applied from the accepting edge onwards,
                    // so a_out/b_out stay 0 and busy rises together with it.
                    state_s     = DRIVE;
                    vec_s       = 2'd0;
                    hold_cnt_s  = 8'd0;
                    fail_mask_s = 4'b0000;
                    pass_s      = 1'b0;
                    busy_s      = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end

            DRIVE: begin
                busy_s = 1'b1;
                if (hold_cnt_r == HOLD_LAST) begin
                    // Last hold cycle: y_in has settled for this vector.
                    if (y_in != expected_bit(vec_r)) begin
                        fail_mask_s[vec_r] = 1'b1;
                    end else begin
                        fail_mask_s[vec_r] = fail_mask_r[vec_r];
                    end
                    hold_cnt_s = 8'd0;
                    if (vec_r == 2'd3) begin
                        state_s = DONE;
                        vec_s   = 2'd0;
                        a_s     = 1'b0;
                        b_s     = 1'b0;
                        busy_s  = 1'b0;
                    end else begin
                        vec_s = vec_r + 2'd1;
                        a_s   = vec_s[1];
                        b_s   = vec_s[0];
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
                end
            end

            DONE: begin
                // The verdict is registered together with the done pulse,
                // so both become visible in the same cycle.
                state_s = IDLE;
                a_s     = 1'b0;
                b_s     = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b1;
                pass_s  = (fail_mask_r == 4'b0000);
            end

            default: begin
                state_s    = IDLE;
                vec_s      = 2'd0;
                hold_cnt_s = 8'd0;
                a_s        = 1'b0;
                b_s        = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            vec_r       <= 2'd0;
            hold_cnt_r  <= 8'd0;
            a_r         <= 1'b0;
            b_r         <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_mask_r <= 4'b0000;
        end else begin
            state_r     <= state_s;
            vec_r       <= vec_s;
            hold_cnt_r  <= hold_cnt_s;
            a_r         <= a_s;
            b_r         <= b_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            fail_mask_r <= fail_mask_s;
        end
    end

    assign a_out     = a_r;
    assign b_out     = b_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail_mask = fail_mask_r;

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed bench for gate_bist. One instance with HOLD=10 is
// driven by a behavioural gate model (AND, OR or AND with glitches). A second
// instance with HOLD=1 has its y_in tied low.
module tb_gate_bist;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start10;
    logic       y10;
    logic       a10, b10, busy10, done10, pass10;
    logic [3:0] mask10;

    logic       start1;
    logic       y1;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] mask1;

    logic [1:0] gate_sel;   // 0 = AND, 1 = OR
    logic       glitch;     // inverts the gate output while set

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign y10 = ((gate_sel == 2'd1) ? (a10 | b10) : (a10 & b10)) ^ glitch;
    assign y1  = 1'b0;

    gate_bist #(.EXPECTED(4'b1000), .HOLD(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start10), .y_in(y10),
        .a_out(a10), .b_out(b10), .busy(busy10), .done(done10),
        .pass(pass10), .fail_mask(mask10)
    );

    gate_bist #(.EXPECTED(4'b1000), .HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_mask(mask1)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full HOLD=10 run from a start pulse, checking timing and verdict.
    task automatic run10(input logic [1:0] gsel, input bit glitch_en, input bit repulse,
                         input logic [3:0] exp_mask, input logic exp_pass);
        gate_sel = gsel;
        glitch   = 1'b0;
        start10  = 1'b1;
        tick();                         // edge E0 accepts the start
        start10  = 1'b0;
        for (int c = 0; c < 41; c++) begin
            // Wrong value on hold cycles 0..8, correct on cycle 9.
            glitch  = glitch_en && ((c % 10) != 9);
            start10 = repulse && (c == 15);
            if (c < 40) begin
                if ((c % 10) == 0 || (c % 10) == 9) begin
                    chk("a_vec", {7'd0, a10}, 8'(((c / 10) >> 1) & 1));
                    chk("b_vec", {7'd0, b10}, 8'((c / 10) & 1));
                end
                chk("busy_run", {7'd0, busy10}, 8'd1);
            end else begin
                chk("busy_done_state", {7'd0, busy10}, 8'd0);
            end
            chk("done_early", {7'd0, done10}, 8'd0);
            tick();
        end
        glitch  = 1'b0;
        start10 = 1'b0;
        chk("done_pulse", {7'd0, done10}, 8'd1);
        chk("busy_at_done", {7'd0, busy10}, 8'd0);
        chk("pass", {7'd0, pass10}, {7'd0, exp_pass});
        chk("fail_mask", {4'd0, mask10}, {4'd0, exp_mask});
        tick();
        chk("done_single", {7'd0, done10}, 8'd0);
        chk("pass_hold", {7'd0, pass10}, {7'd0, exp_pass});
        chk("mask_hold", {4'd0, mask10}, {4'd0, exp_mask});
    endtask

    initial begin
        rst_n    = 1'b0;
        start10  = 1'b0;
        start1   = 1'b0;
        gate_sel = 2'd0;
        glitch   = 1'b0;
        tick();
        tick();
        chk("rst_busy", {7'd0, busy10}, 8'd0);
        chk("rst_done", {7'd0, done10}, 8'd0);
        chk("rst_pass", {7'd0, pass10}, 8'd0);
        chk("rst_mask", {4'd0, mask10}, 8'd0);
        chk("rst_ab", {6'd0, a10, b10}, 8'd0);
        chk("rst_busy1", {7'd0, busy1}, 8'd0);
        rst_n = 1'b1;
        tick();

        // AND gate, correct table.
        run10(2'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
        // OR gate against the AND table.
        run10(2'd1, 1'b0, 1'b0, 4'b0110, 1'b0);
        // Glitches before the sampling cycle are ignored.
        run10(2'd0, 1'b1, 1'b0, 4'b0000, 1'b1);
        // Start re-pulsed mid-run does not disturb timing.
        run10(2'd0, 1'b0, 1'b1, 4'b0000, 1'b1);

        // HOLD=1 with y_in tied low.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("h1_busy", {7'd0, busy1}, 8'd1);
            chk("h1_ab", {6'd0, a1, b1}, 8'(c));
            tick();
        end
        chk("h1_busy_off", {7'd0, busy1}, 8'd0);
        chk("h1_done_early", {7'd0, done1}, 8'd0);
        tick();
        chk("h1_done", {7'd0, done1}, 8'd1);
        chk("h1_pass", {7'd0, pass1}, 8'd0);
        chk("h1_mask", {4'd0, mask1}, 8'b0000_1000);
        tick();
        chk("h1_done_off", {7'd0, done1}, 8'd0);

        // Start held high: OR run, then a back-to-back AND run.
        gate_sel = 2'd1;
        start10  = 1'b1;
        tick();
        for (int c = 0; c < 41; c++) begin
            chk("held_busy", {7'd0, busy10}, (c < 40) ? 8'd1 : 8'd0);
            chk("held_done_early", {7'd0, done10}, 8'd0);
            tick();
        end
        chk("held_done", {7'd0, done10}, 8'd1);
        chk("held_pass", {7'd0, pass10}, 8'd0);
        chk("held_mask", {4'd0, mask10}, 8'b0000_0110);
        gate_sel = 2'd0;
        tick();                         // second run accepted here
        chk("held_restart_busy", {7'd0, busy10}, 8'd1);
        chk("held_restart_done", {7'd0, done10}, 8'd0);
        chk("held_clear_mask", {4'd0, mask10}, 8'd0);
        chk("held_clear_pass", {7'd0, pass10}, 8'd0);
        start10 = 1'b0;
        for (int c = 0; c < 41; c++) begin
            tick();
        end
        chk("held_run2_done", {7'd0, done10}, 8'd1);
        chk("held_run2_pass", {7'd0, pass10}, 8'd1);
        chk("held_run2_mask", {4'd0, mask10}, 8'd0);
        tick();

        // Reset in the middle of a run.
        start10 = 1'b1;
        tick();
        start10 = 1'b0;
        for (int c = 0; c < 22; c++) begin
            tick();
        end
        chk("pre_rst_ab", {6'd0, a10, b10}, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ab", {6'd0, a10, b10}, 8'd0);
        chk("arst_busy", {7'd0, busy10}, 8'd0);
        chk("arst_done", {7'd0, done10}, 8'd0);
        chk("arst_pass", {7'd0, pass10}, 8'd0);
        chk("arst_mask", {4'd0, mask10}, 8'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            chk("arst_no_done", {7'd0, done10}, 8'd0);
            chk("arst_idle", {7'd0, busy10}, 8'd0);
            tick();
        end
        run10(2'd0, 1'b0, 1'b0, 4'b0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Hardware stimulus/checker for a 2-input combinational gate under test.
- Drives exhaustive input vectors a,b in the order 00, 01, 10, 11, holding each for a programmable number of cycles.
- Samples the gate output y on the last hold cycle of each vector and compares it against a parameterised truth table.
- Reports per-vector mismatches and an overall pass flag. It is the in-silicon counterpart of the gate testbenches: it drives and judges instead of being driven.

Parameters:
- EXPECTED, 4'b1000, expected y per vector; bit index = {a,b}. Default is the AND table.
- HOLD, 10, cycles each vector is held. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a test run; sampled only in IDLE
- y_in  input  1  output of the gate under test, combinational from a_out/b_out
- a_out  output  1  gate input a
- b_out  output  1  gate input b
- busy  output  1  high while vectors are being driven
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  run result: 1 = all vectors matched; valid from done until the next accepted start
- fail_mask  output  4  bit {a,b} set if that vector mismatched; same validity as pass

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0.
  - Vector index and hold counter cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - a_out=b_out=0, busy=0.
  - On start=1 at a rising edge: go to DRIVE, vector=0, hold_cnt=0, fail_mask cleared, pass cleared, busy=1.
- DRIVE:
  - a_out=vector[1], b_out=vector[0], busy=1.
  - hold_cnt increments each cycle.
  - On the edge where hold_cnt==HOLD-1, sample y_in. If y_in != EXPECTED[vector], set fail_mask[vector].
  - If vector<3: vector+1, hold_cnt=0.
  - If vector==3: go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0, a_out=b_out=0.
  - pass = (final fail_mask == 0), registered with the DONE transition so it is valid in the done cycle.
  - Next state IDLE.
- Latency:
  - start accepted at edge E0; DRIVE occupies cycles E1..E(4*HOLD).
  - done is high for the cycle following edge E(4*HOLD+1).
  - Each vector is applied for exactly HOLD cycles.
- Sampling point: y_in is sampled only on the last hold cycle of each vector. Glitches or mismatches in earlier hold cycles are ignored.
- HOLD=1: each vector lasts one cycle and is sampled on its only edge. Total busy = 4 cycles.
- start while busy or in DONE: ignored. It has no effect on the run in progress and is not queued.
- start held continuously high: a new run begins on the edge after DONE, since IDLE lasts at least one cycle.
- pass and fail_mask hold their values through IDLE until the next accepted start clears them.
- Reset mid-run: immediate abort to reset values. No done pulse; pass=0.
- The hold counter needs 8 bits. It never exceeds HOLD-1.

Test Plan:
- AND gate on y_in, EXPECTED=4'b1000, HOLD=10, pulse start: a_out/b_out step 00, 01, 10, 11 every 10 cycles; done pulses 41 cycles after the start edge; pass=1, fail_mask=4'b0000.
- OR gate on y_in with EXPECTED=4'b1000: pass=0, fail_mask=4'b0110.
- y_in tied 0, EXPECTED=4'b1000, HOLD=1: busy high for exactly 4 cycles; done on cycle 5; fail_mask=4'b1000, pass=0.
- y_in glitch to the wrong value during cycles 0..8 of each vector, correct value on cycle 9, HOLD=10: pass=1, which confirms the sampling point.
- start re-pulsed at cycle 15 of a run: run timing unchanged; single done at cycle 41. Then start held high: second run begins one cycle after done, and fail_mask/pass clear on acceptance.
- rst_n low at cycle 22 of a run: outputs go to reset values immediately (asynchronously); no done pulse. A fresh start afterwards completes normally with pass=1.
